// File: rtl/uart_rx_fsm_sampler.sv
// uart_rx_fsm_sampler
//   Control and datapath stage of a UART receiver. It works beside an
//   external edge/bit counter: this block drives the counter enables, takes
//   a 3-point majority vote of RX_IN around mid-bit, walks the frame through
//   start, data, optional parity and stop, deserialises LSB-first into
//   P_DATA, and reports the frame outcome as single-cycle pulses.
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   RX_IN        serial line (idles high, already synchronised)
//   PAR_EN       1 = frame carries a parity bit
//   PAR_TYP      0 = even parity, 1 = odd parity
//   prescaler    oversampling ratio (even, 8..30), quasi-static per frame
//   Edge_Counter edge index within the current bit, from the counter
//   Bit_Counter  data-bit index, from the counter
//   Done         high when Edge_Counter == prescaler-1
//   Edge_EN_CNT  enables the edge counter
//   Bit_EN_CNT   enables the bit counter (0 clears it)
//   P_DATA       received byte
//   Data_Valid   1-cycle pulse: frame good
//   Par_Err      1-cycle pulse: parity mismatch
//   Stp_Err      1-cycle pulse: stop bit sampled low
module uart_rx_fsm_sampler #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescaler,
  input  logic [PRESCALE_W-1:0] Edge_Counter,
  input  logic [2:0]            Bit_Counter,
  input  logic                  Done,
  output logic                  Edge_EN_CNT,
  output logic                  Bit_EN_CNT,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stp_Err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t                state_q;
  logic                  s0_q, s1_q, s2_q;
  logic                  sampled_q;
  logic                  par_bad_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q, par_err_q, stp_err_q;

  logic [PRESCALE_W-1:0] mid, mid_m1, mid_p1, mid_p2, mid_p3;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Sample points around the middle of the bit; legal prescalers keep
  // mid+3 at or below prescaler-1, so the vote and the data shift both
  // complete no later than the Done edge.
  always_comb begin
    mid    = prescaler >> 1;
    mid_m1 = mid - PRESCALE_W'(1);
    mid_p1 = mid + PRESCALE_W'(1);
    mid_p2 = mid + PRESCALE_W'(2);
    mid_p3 = mid + PRESCALE_W'(3);
  end

  // Enables are Moore outputs decoded straight from the state register.
  assign Edge_EN_CNT = (state_q != IDLE);
  assign Bit_EN_CNT  = (state_q == DATA);

  assign P_DATA     = p_data_q;
  assign Data_Valid = data_valid_q;
  assign Par_Err    = par_err_q;
  assign Stp_Err    = stp_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      sampled_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;

      if (Edge_EN_CNT) begin
        if (Edge_Counter == mid_m1) s0_q <= RX_IN;
        if (Edge_Counter == mid)    s1_q <= RX_IN;
        if (Edge_Counter == mid_p1) s2_q <= RX_IN;
        if (Edge_Counter == mid_p2) sampled_q <= majority3(s0_q, s1_q, s2_q);
      end

      case (state_q)
        IDLE: begin
          if (!RX_IN) begin
            state_q   <= START;
            par_bad_q <= 1'b0;
          end
        end
        START: begin
          // A start bit that votes high was a glitch on the idle line.
          if (Done) state_q <= sampled_q ? IDLE : DATA;
        end
        DATA: begin
          // Shift right so the first bit received ends up in bit 0.
          if (Edge_Counter == mid_p3)
            p_data_q <= {sampled_q, p_data_q[DATA_WIDTH-1:1]};
          if (Done && (Bit_Counter == LAST_BIT))
            state_q <= PAR_EN ? PARITY : STOP;
        end
        PARITY: begin
          if (Done) begin
            par_bad_q <= (sampled_q != ((^p_data_q) ^ PAR_TYP));
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (Done) begin
            state_q <= IDLE;
            // A framing error outranks a parity error.
            if (!sampled_q)     stp_err_q    <= 1'b1;
            else if (par_bad_q) par_err_q    <= 1'b1;
            else                data_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm_sampler.sv
module tb_uart_rx_fsm_sampler;

  localparam logic [1:0] K_OK  = 2'd0;
  localparam logic [1:0] K_PAR = 2'd1;
  localparam logic [1:0] K_STP = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [4:0] prescaler = 5'd8;
  logic [4:0] ec = 5'd0;
  logic [2:0] bc = 3'd0;
  logic       Done;
  logic       Edge_EN_CNT, Bit_EN_CNT;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_Err, Stp_Err;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic done_prev = 1'b0;

  uart_rx_fsm_sampler #(.DATA_WIDTH(8), .PRESCALE_W(5)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .prescaler(prescaler), .Edge_Counter(ec), .Bit_Counter(bc), .Done(Done),
    .Edge_EN_CNT(Edge_EN_CNT), .Bit_EN_CNT(Bit_EN_CNT), .P_DATA(P_DATA),
    .Data_Valid(Data_Valid), .Par_Err(Par_Err), .Stp_Err(Stp_Err)
  );

  always #5 CLK = ~CLK;

  // Companion edge/bit counter the receiver expects beside it.
  assign Done = (ec == prescaler - 5'd1);
  always @(posedge CLK) begin
    if (RST || !Edge_EN_CNT) ec <= 5'd0;
    else if (Done)           ec <= 5'd0;
    else                     ec <= ec + 5'd1;
    if (RST || !Bit_EN_CNT)  bc <= 3'd0;
    else if (Done)           bc <= bc + 3'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a flag is presented, pop the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    logic [2:0] want;
    if (!RST && (Data_Valid || Par_Err || Stp_Err)) begin
      chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        want = (e.kind == K_STP) ? 3'b100 : (e.kind == K_PAR) ? 3'b010 : 3'b001;
        chk("flags", 32'({Stp_Err, Par_Err, Data_Valid}), 32'(want));
        chk("p_data", 32'(P_DATA), 32'(e.data));
        chk("flag_after_done", 32'(done_prev), 32'd1);
        chk("idle_edge_en", 32'(Edge_EN_CNT), 32'd0);
        chk("idle_edge_cnt", 32'(ec), 32'd0);
      end
    end
    done_prev <= Done;
  end

  task automatic drive_cycle(input logic v);
    @(posedge CLK);
    #1;
    RX_IN = v;
  endtask

  // Reference model: the outcome follows from the frame contents alone;
  // a single-clock glitch on one sample cannot sway the 3-point vote.
  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_bit,
                            input int glitch_bit, input int gap);
    logic [10:0] bits;
    int nb;
    int ps;
    exp_t e;
    ps = int'(prescaler);
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (PAR_EN) begin
      bits[nb] = (^d) ^ PAR_TYP ^ flip;
      nb++;
    end
    bits[nb] = stop_bit;
    nb++;
    e.data = d;
    if (!stop_bit)           e.kind = K_STP;
    else if (PAR_EN && flip) e.kind = K_PAR;
    else                     e.kind = K_OK;
    exp_q.push_back(e);
    for (int b = 0; b < nb; b++)
      for (int p = 0; p < ps; p++)
        drive_cycle((glitch_bit >= 0 && b == glitch_bit + 1 && p == ps / 2 + 1) ? ~bits[b] : bits[b]);
    for (int g = 0; g < gap; g++) drive_cycle(1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_edge_en"}, 32'(Edge_EN_CNT), 32'd0);
    chk({tag, "_bit_en"},  32'(Bit_EN_CNT), 32'd0);
    chk({tag, "_pdata"},   32'(P_DATA), 32'd0);
    chk({tag, "_flags"},   32'({Data_Valid, Par_Err, Stp_Err}), 32'd0);
  endtask

  initial begin
    logic [7:0] abort_d;
    logic [7:0] rd;
    // Reset held
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs("reset");
    RST = 1'b0;

    // Idle line for 100 cycles
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b1);
      if (i % 25 == 24) chk_reset_outputs("idle");
    end

    // Good frame, no parity
    send_frame(8'hA5, 1'b0, 1'b1, -1, 3);

    // Start-bit glitch, then a real frame
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    drive_cycle(1'b1);
    chk("glitch_start_en", 32'(Edge_EN_CNT), 32'd1);
    repeat (10) drive_cycle(1'b1);
    chk("glitch_back_idle", 32'(Edge_EN_CNT), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b1, -1, 3);

    // Majority vote rejects single-clock pulses
    send_frame(8'hFF, 1'b0, 1'b1, 3, 3);
    send_frame(8'h00, 1'b0, 1'b1, 3, 3);

    // Parity
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    send_frame(8'h07, 1'b0, 1'b1, -1, 3);
    send_frame(8'h07, 1'b1, 1'b1, -1, 3);
    PAR_TYP = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1, -1, 3);

    // Back-to-back frames
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    send_frame(8'h96, 1'b0, 1'b1, -1, 0);
    send_frame(8'h69, 1'b0, 1'b1, -1, 3);

    // Stop error at prescaler 16
    prescaler = 5'd16;
    send_frame(8'h81, 1'b0, 1'b0, -1, 3);

    // Reset during bit 4 of the next frame
    abort_d = 8'hC3;
    repeat (16) drive_cycle(1'b0);
    for (int b = 0; b < 4; b++) repeat (16) drive_cycle(abort_d[b]);
    repeat (5) drive_cycle(abort_d[4]);
    chk("midframe_edge_en", 32'(Edge_EN_CNT), 32'd1);
    chk("midframe_bit_en", 32'(Bit_EN_CNT), 32'd1);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    RX_IN = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_reset_outputs("abort");
    repeat (20) drive_cycle(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 3);

    // Randomised frames
    for (int n = 0; n < 20; n++) begin
      prescaler = 5'(2 * $urandom_range(4, 15));
      PAR_EN = 1'($urandom_range(0, 1));
      PAR_TYP = 1'($urandom_range(0, 1));
      rd = 8'($urandom);
      send_frame(rd, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                 int'($urandom_range(2, 4)));
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm_sampler.md
Name: uart_rx_fsm_sampler

Overview:
- Control and datapath stage of the UART receiver that sits beside the edge/bit counter.
- Samples RX_IN with a 3-point majority vote at mid-bit and drives the counter enables.
- Walks the frame through start, data, optional parity and stop, then deserialises LSB-first into P_DATA.
- Flags a good frame or a parity/stop error to the downstream consumer.

Parameters:
- DATA_WIDTH, 8, data bits per frame; fixed by the 3-bit Bit_Counter.
- PRESCALE_W, 5, width of prescaler and Edge_Counter.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  synchronous, active-high reset
- RX_IN  input  1  serial line; idles high; already synchronised
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- prescaler  input  PRESCALE_W  oversampling ratio; legal values are even and 8..30; quasi-static per frame
- Edge_Counter  input  PRESCALE_W  edge count within the current bit, from the counter
- Bit_Counter  input  3  data-bit index, from the counter
- Done  input  1  high when Edge_Counter == prescaler-1
- Edge_EN_CNT  output  1  enables the edge counter
- Bit_EN_CNT  output  1  enables the bit counter; 0 clears it
- P_DATA  output  DATA_WIDTH  received byte
- Data_Valid  output  1  1-cycle pulse: frame OK
- Par_Err  output  1  1-cycle pulse: parity mismatch
- Stp_Err  output  1  1-cycle pulse: stop bit sampled low

Behaviour:
- Reset (RST=1 at a CLK edge):
  - State = IDLE.
  - Edge_EN_CNT, Bit_EN_CNT, Data_Valid, Par_Err and Stp_Err all = 0.
  - P_DATA = 0; sample registers = 0.
  - Reset mid-frame aborts the frame with no flag pulse.
- Moore enables, decoded from the state register:
  - Edge_EN_CNT = 1 in START, DATA, PARITY and STOP.
  - Bit_EN_CNT = 1 only in DATA.
- Sampler:
  - mid = prescaler>>1.
  - RX_IN is registered into s0, s1 and s2 when Edge_Counter equals mid-1, mid and mid+1 respectively, only while Edge_EN_CNT=1.
  - sampled_bit = majority(s0, s1, s2), registered at Edge_Counter == mid+2.
  - For legal prescaler values, sampled_bit is valid before Done.
- IDLE:
  - RX_IN==0 at a CLK edge moves to START.
  - The edge counter holds 0 here, because each active state leaves on Done, which wraps the counter.
- START, on Done:
  - sampled_bit==1 (glitch) goes to IDLE, with no flags.
  - Otherwise goes to DATA.
- DATA:
  - On the cycle after the mid+2 sample, shift P_DATA right by one and load sampled_bit into the MSB, so after 8 bits the first bit received sits in P_DATA[0].
  - Done with Bit_Counter==7 goes to PARITY if PAR_EN=1, else to STOP.
- PARITY, on Done:
  - expected = ^P_DATA XOR PAR_TYP.
  - A mismatch with sampled_bit sets internal par_bad.
  - Then go to STOP.
- STOP, on Done:
  - Go to IDLE.
  - On the next cycle pulse exactly one of the following for 1 cycle:
    - Stp_Err, if sampled_bit==0. This has priority; par_bad is dropped.
    - Par_Err, if par_bad.
    - Data_Valid, otherwise.
  - par_bad clears on entry to START.
- P_DATA updates only during DATA shifts. It is stable from the Data_Valid pulse until the next frame's first data shift.
- Back-to-back frames: a start bit immediately after the stop is accepted. IDLE occupies 1 cycle, so sampling slips 1 clock, which is within tolerance.
- PAR_EN, PAR_TYP and prescaler must not change mid-frame; results are undefined if they do.

Test Plan:
- Reset/idle: prescaler=8, PAR_EN=0, RX_IN=1 for 100 cycles. Required: no enables, no flags, P_DATA=0.
- Good frame: prescaler=8, PAR_EN=0, send 0xA5 (8-clock bits). Required:
  - Data_Valid high for exactly 1 cycle, 1 cycle after the stop bit's Done.
  - P_DATA=0xA5; Par_Err=Stp_Err=0.
  - Edge_Counter=0 on return to IDLE.
- Start glitch: RX_IN low for 2 clocks, then high, prescaler=8. Required: return to IDLE after 8 edges; no flags; a following frame 0x3C is received correctly.
- Majority vote:
  - Send 0xFF with a 1-clock low pulse at Edge_Counter==4 inside bit 3. Required: P_DATA=0xFF.
  - Send 0x00 with a 1-clock high pulse at the same point. Required: P_DATA=0x00.
- Parity:
  - PAR_EN=1, PAR_TYP=0, data 0x07, parity bit 1. Required: Data_Valid.
  - Same frame with parity bit 0. Required: Par_Err pulse, no Data_Valid.
  - PAR_TYP=1, data 0x07, parity bit 0. Required: Data_Valid.
- Stop error and reset: prescaler=16, data 0x81 with stop bit 0. Required: Stp_Err pulse only. Then assert RST during bit 4 of the next frame. Required: outputs at reset values the next cycle; a following frame 0x5A is received cleanly.
